// File: rtl/arm_fetch_queue.sv
// Instruction-fetch front end: PC generator plus in-order prefetch queue with redirect flush.
// Optional FETCH_PERF_EN adds saturating redirect / dropped-response / stall counters.
module arm_fetch_queue #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSN_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLOCK,
    input  logic              RESET,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INSN_W-1:0] out_insn,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_redirects,
    output logic [31:0]       perf_dropped,
    output logic [31:0]       perf_stall,
`endif
    output logic              protocol_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_RESERVED,
        SLOT_FILLED
    } slot_t;

    slot_t             slot_st   [DEPTH];
    logic [ADDR_W-1:0] slot_pc   [DEPTH];
    logic [INSN_W-1:0] slot_insn [DEPTH];

    logic [ADDR_W-1:0] fetch_pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  fill_ptr;
    logic [CNT_W-1:0]  cnt;       // reserved + filled slots
    logic [CNT_W-1:0]  res_cnt;   // reserved, still awaiting data
    logic [CNT_W-1:0]  drop_cnt;  // stale responses still to discard

    logic issue;
    logic pop;
    logic fill;
    logic drop;
    logic stray;
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_req  = !RESET && !redirect_valid && (cnt < CNT_W'(DEPTH)) && (drop_cnt == '0);
    assign imem_addr = fetch_pc;

    assign out_valid = (slot_st[rd_ptr] == SLOT_FILLED);
    assign out_pc    = slot_pc[rd_ptr];
    assign out_insn  = slot_insn[rd_ptr];

    assign issue = imem_req && imem_ready;
    assign pop   = out_valid && out_ready;
    assign drop  = imem_rvalid && (drop_cnt != '0);
    assign fill  = imem_rvalid && (drop_cnt == '0) && (res_cnt != '0);
    assign stray = imem_rvalid && (drop_cnt == '0) && (res_cnt == '0);

    // Queue state; redirect overrides issue/fill/pop but still accounts for the in-flight response.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            fetch_pc     <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fill_ptr     <= '0;
            cnt          <= '0;
            res_cnt      <= '0;
            drop_cnt     <= '0;
            protocol_err <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_st[i]   <= SLOT_FREE;
                slot_pc[i]   <= '0;
                slot_insn[i] <= '0;
            end
        end else begin
            if (stray) begin
                protocol_err <= 1'b1;
            end
            if (redirect_valid) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    slot_st[i] <= SLOT_FREE;
                end
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fill_ptr <= '0;
                cnt      <= '0;
                res_cnt  <= '0;
                fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
                drop_cnt <= drop_cnt + res_cnt - CNT_W'(drop || fill);
            end else begin
                if (issue) begin
                    slot_st[wr_ptr] <= SLOT_RESERVED;
                    slot_pc[wr_ptr] <= fetch_pc;
                    wr_ptr          <= wr_ptr + PTR_W'(1);
                    fetch_pc        <= fetch_pc + ADDR_W'(4);
                end
                if (fill) begin
                    slot_st[fill_ptr]   <= SLOT_FILLED;
                    slot_insn[fill_ptr] <= imem_rdata;
                    fill_ptr            <= fill_ptr + PTR_W'(1);
                end
                if (pop) begin
                    slot_st[rd_ptr] <= SLOT_FREE;
                    rd_ptr          <= rd_ptr + PTR_W'(1);
                end
                if (drop) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
                cnt     <= cnt + CNT_W'(issue) - CNT_W'(pop);
                res_cnt <= res_cnt + CNT_W'(issue) - CNT_W'(fill);
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            perf_redirects <= '0;
            perf_dropped   <= '0;
            perf_stall     <= '0;
        end else begin
            if (redirect_valid && (perf_redirects != '1)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if (drop && (perf_dropped != '1)) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
            if (out_valid && !out_ready && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arm_fetch_queue.sv
// Directed self-checking bench for arm_fetch_queue with an in-order fixed-latency memory model.
module tb_arm_fetch_queue;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_insn;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        protocol_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;
    bit force_rv = 0;

    logic [63:0] pend_addr[$];
    int          pend_due[$];
    logic [63:0] req_log[$];
    logic [63:0] pop_pc[$];
    logic [31:0] pop_insn[$];

    arm_fetch_queue dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_insn(out_insn),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_EN
        .perf_redirects(perf_redirects),
        .perf_dropped(perf_dropped),
        .perf_stall(perf_stall),
`endif
        .protocol_err(protocol_err)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    // One clock: log handshakes, advance the memory model, present the next response.
    task automatic tick();
        logic        hs;
        logic [63:0] ha;
        logic        pp;
        logic [63:0] ppc;
        logic [31:0] pin;
        hs  = imem_req && imem_ready;
        ha  = imem_addr;
        pp  = out_valid && out_ready;
        ppc = out_pc;
        pin = out_insn;
        @(posedge CLOCK);
        #1;
        if (hs) begin
            req_log.push_back(ha);
            pend_addr.push_back(ha);
            pend_due.push_back(cyc + lat);
        end
        if (pp) begin
            pop_pc.push_back(ppc);
            pop_insn.push_back(pin);
        end
        cyc++;
        if (force_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            force_rv    = 0;
        end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'(pend_addr[0]) | 32'hE000_0000;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
        end
        #1;
    endtask

    task automatic clear_model();
        pend_addr.delete();
        pend_due.delete();
        req_log.delete();
        pop_pc.delete();
        pop_insn.delete();
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        force_rv       = 0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        imem_ready     = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        clear_model();
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        cyc = 0;
        #1;
    endtask

    task automatic wait_pop(input int n);
        int k;
        k = 0;
        while (pop_pc.size() < n && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        checks++;
        if (out_insn !== 32'h0) begin errors++; $display("FAIL reset_insn: got %h want 0", out_insn); end
        checks++;
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", protocol_err); end
    endtask

    task automatic test_fill_stall();
        do_reset();
        lat = 1;
        imem_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            errors++; $display("FAIL first_req: req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b want 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_insn !== 32'hE000_0000) begin
            errors++; $display("FAIL first_out: v=%b pc=%h insn=%h want 1/0/e0000000", out_valid, out_pc, out_insn);
        end
        repeat (6) tick();
        checks++;
        if (req_log.size() != 4) begin errors++; $display("FAIL stall_count: got %0d requests want 4", req_log.size()); end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            checks++;
            if (req_log[i] !== 64'(i * 4)) begin
                errors++; $display("FAIL req_addr[%0d]: got %h want %h", i, req_log[i], 64'(i * 4));
            end
        end
        checks++;
        if (imem_req !== 1'b0 || out_pc !== 64'h0) begin
            errors++; $display("FAIL stall_hold: req=%b pc=%h want 0/0", imem_req, out_pc);
        end
        out_ready = 1'b1;
        wait_pop(5);
        checks++;
        if (pop_pc.size() < 5) begin errors++; $display("FAIL drain_timeout: got %0d pops want 5", pop_pc.size()); end
        for (int i = 0; i < 5 && i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== 64'(i * 4) || pop_insn[i] !== (32'(i * 4) | 32'hE000_0000)) begin
                errors++; $display("FAIL drain[%0d]: pc=%h insn=%h want pc %h", i, pop_pc[i], pop_insn[i], 64'(i * 4));
            end
        end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        lat = 4;
        imem_ready = 1'b1;
        #1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_noreq: got %b want 0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", out_valid); end
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 3 || imem_addr !== 64'h100) begin
            errors++; $display("FAIL redir_resume: waited %0d addr=%h want 3/100", n, imem_addr);
        end
        out_ready = 1'b1;
        wait_pop(1);
        checks++;
        if (pop_pc.size() < 1 || pop_pc[0] !== 64'h100 || pop_insn[0] !== 32'hE000_0100) begin
            errors++; $display("FAIL redir_first_out: pops=%0d pc=%h want 100",
                               pop_pc.size(), (pop_pc.size() > 0) ? pop_pc[0] : 64'hx);
        end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        lat = 2;
        imem_ready = 1'b1;
        #1;
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rr_drop: req=%b valid=%b want 0/0", imem_req, out_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin
            errors++; $display("FAIL rr_resume: req=%b addr=%h want 1/200", imem_req, imem_addr);
        end
        out_ready = 1'b1;
        wait_pop(1);
        checks++;
        if (pop_pc.size() < 1 || pop_pc[0] !== 64'h200 || pop_insn[0] !== 32'hE000_0200) begin
            errors++; $display("FAIL rr_first_out: pops=%0d pc=%h want 200",
                               pop_pc.size(), (pop_pc.size() > 0) ? pop_pc[0] : 64'hx);
        end
    endtask

    task automatic test_protocol_err();
        do_reset();
        lat = 1;
        force_rv = 1;
        tick();
        checks++;
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL perr_early: got %b want 0", protocol_err); end
        tick();
        checks++;
        if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %b want 1", protocol_err); end
        repeat (3) tick();
        checks++;
        if (protocol_err !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 64'h0) begin
            errors++; $display("FAIL perr_sticky: perr=%b valid=%b addr=%h want 1/0/0", protocol_err, out_valid, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        lat = 1;
        imem_ready = 1'b1;
        #1;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || protocol_err !== 1'b1) begin
            errors++; $display("FAIL mid_pre: valid=%b perr=%b want 1/1", out_valid, protocol_err);
        end
        RESET = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || protocol_err !== 1'b0) begin
            errors++; $display("FAIL mid_async: valid=%b req=%b perr=%b want 0/0/0", out_valid, imem_req, protocol_err);
        end
        clear_model();
        imem_ready = 1'b1;
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            errors++; $display("FAIL mid_restart: req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_redirect();
        test_redirect_rvalid();
        test_protocol_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_fetch_queue.md
Name: arm_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined ARM core.
- Replaces the bare PC register and IC input with a PC generator and an in-order prefetch queue of DEPTH entries.
- Talks to instruction memory over a request/response interface that allows multiple outstanding fetches.
- Delivers {PC, instruction} to the IF/ID stage under valid/ready backpressure; a branch redirect flushes the queue and discards stale in-flight responses.

Parameters:
ADDR_W, 64, PC and memory address width
INSN_W, 32, instruction width
DEPTH, 4, queue entries (power of two, >=2); also the maximum number of outstanding requests
RESET_PC, 0, fetch address loaded at reset

Ports:
CLOCK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_W  fetch address (word aligned)
imem_ready  input  1  memory accepts request when imem_req && imem_ready
imem_rvalid  input  1  in-order response valid, one per accepted request
imem_rdata  input  INSN_W  response instruction
out_valid  output  1  head entry holds a returned instruction
out_ready  input  1  IF/ID accepts head
out_pc  output  ADDR_W  PC of head entry
out_insn  output  INSN_W  instruction of head entry
redirect_valid  input  1  branch taken; flush and refetch
redirect_pc  input  ADDR_W  new fetch address; bits [1:0] forced to 0
protocol_err  output  1  sticky: rvalid received with nothing pending

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC; all entries invalid; rd/wr pointers = 0; drop_cnt = 0.
  - imem_req = 0, out_valid = 0, out_pc = 0, out_insn = 0, protocol_err = 0.
- Entry state:
  - Each slot is FREE, RESERVED (request accepted, pc stored), or FILLED (insn stored).
  - Slots are allocated at wr_ptr on request handshake and filled in allocation order.
- Issue:
  - imem_req = !redirect_valid && reserved_count < DEPTH && drop_cnt == 0.
  - reserved_count counts RESERVED plus FILLED entries.
  - imem_addr = fetch_pc.
  - On handshake: the slot takes pc = fetch_pc, fetch_pc += 4 (wraps modulo 2^ADDR_W), wr_ptr++.
- Response:
  - imem_rvalid with drop_cnt > 0: decrement drop_cnt, data discarded.
  - imem_rvalid otherwise: the oldest RESERVED slot becomes FILLED with imem_rdata.
  - imem_rvalid with no RESERVED slot and drop_cnt == 0: ignored, protocol_err <= 1 (held until RESET).
- Output:
  - out_valid = head slot FILLED; out_pc/out_insn are driven from the head slot.
  - Pop on out_valid && out_ready: slot becomes FREE, rd_ptr++.
  - Minimum latency: request accepted in cycle N, response in cycle N+k, so out_valid is asserted from cycle N+k+1.
- Simultaneous events:
  - Pop and fill of different slots, plus issue, can all occur in one cycle. A full queue frees a slot by pop, but issue is evaluated on the pre-pop count, so the freed slot is reused no earlier than the next cycle.
- Redirect (highest priority):
  - Takes effect at the next edge: all slots become FREE, pointers = 0, fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - drop_cnt <= drop_cnt + unfilled_reserved - (imem_rvalid ? 1 : 0).
  - No request is issued in the redirect cycle.
  - A pop in the same cycle is still a valid handshake for downstream.
  - out_valid = 0 the cycle after a redirect.
  - Fetching resumes only once drop_cnt reaches 0, which bounds drop_cnt to DEPTH.
- Reset mid-operation:
  - Immediate clear of all state.
  - Instruction memory is reset by the same RESET, so no stale responses arrive.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_redirects[31:0] (redirect cycles), perf_dropped[31:0] (discarded responses) and perf_stall[31:0] (cycles with out_valid && !out_ready).
  - All three counters are saturating and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release with imem_ready=1 and 1-cycle response latency, rdata = pc|0xE000_0000 -> requests 0x0,0x4,0x8,0xC, then stall with 4 slots held; out_valid is asserted cycle 3 with out_pc=0x0, out_insn=0xE000_0000.
- out_ready held 0 -> exactly 4 requests issued, imem_req=0, head stays pc 0x0. Then out_ready=1 -> in-order pcs 0x0,0x4,0x8,0xC,0x10 with no gaps or duplicates.
- 3 requests outstanding with 4-cycle latency, then redirect_pc=0x103 -> drop_cnt=3, next request addr=0x100 only after 3 discarded responses; first out_pc=0x100.
- Redirect in the same cycle as imem_rvalid with 2 unfilled slots -> drop_cnt=1; the following response is discarded.
- imem_rvalid pulsed with an empty queue and drop_cnt=0 -> protocol_err=1 and remains set; queue unchanged.
- RESET asserted mid-stream with 3 entries filled -> out_valid=0, imem_req=0 and protocol_err=0 immediately (asynchronous); after release, the first request addr=RESET_PC.
